// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - select sequencer and nibble capture stage around a 4-channel mux
//
// Steps the mux selects through channels 0..3, waits SETTLE extra cycles after
// each select change, samples {y3,y2,y1,y0} into a shadow frame, then hands the
// packed 16-bit frame downstream over a valid/ready register.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin one scan (honoured only when idle)
//   cont         rescan continuously; looked at only when a frame is handed off
//   s0, s1       registered mux selects, s0 = ch[1], s1 = ch[0]
//   y0..y3       mux outputs, y0 is bit 0 of each captured nibble
//   frame_out    captured frame, bits [4k+3:4k] hold channel k
//   frame_valid  frame_out holds a frame not yet accepted
//   frame_ready  downstream accept
//   busy         a scan or hand-off is in progress

module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cont,
    output logic        s0,
    output logic        s1,
    input  logic        y0,
    input  logic        y1,
    input  logic        y2,
    input  logic        y3,
    output logic [15:0] frame_out,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        busy
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ch;
    logic [3:0]  cnt;
    logic [15:0] shadow;

    // Decoded controls from the output process
    logic out_free;
    logic restart_scan;
    logic next_channel;
    logic count_down;
    logic capture;
    logic load_frame;

    // The output register can take a new frame when empty or being drained this cycle.
    assign out_free = !frame_valid || frame_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (ch == 2'd3) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_SETTLE;
                end
            end
            S_DONE: begin
                // Stall here until the previous frame has been taken.
                if (out_free) begin
                    state_nxt = cont ? S_SETTLE : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy         = (state != S_IDLE);
        restart_scan = 1'b0;
        next_channel = 1'b0;
        count_down   = 1'b0;
        capture      = 1'b0;
        load_frame   = 1'b0;
        case (state)
            S_IDLE: begin
                restart_scan = start;
            end
            S_SETTLE: begin
                count_down = (cnt != 4'd0);
            end
            S_SAMPLE: begin
                capture      = 1'b1;
                next_channel = (ch != 2'd3);
            end
            S_DONE: begin
                load_frame   = out_free;
                restart_scan = out_free && cont;
            end
            default: ;
        endcase
    end

    // Datapath: channel, settle counter, selects, shadow and output registers.
    // Selects are only rewritten on entry to SETTLE, so they hold in IDLE and
    // during a DONE stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch          <= 2'd0;
            cnt         <= 4'd0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            shadow      <= 16'h0000;
            frame_out   <= 16'h0000;
            frame_valid <= 1'b0;
        end else begin
            if (restart_scan) begin
                ch         <= 2'd0;
                cnt        <= SETTLE_CNT;
                {s0, s1}   <= 2'b00;
            end else if (next_channel) begin
                ch         <= ch + 2'd1;
                cnt        <= SETTLE_CNT;
                {s0, s1}   <= ch + 2'd1;
            end else if (count_down) begin
                cnt        <= cnt - 4'd1;
            end

            if (capture) begin
                shadow[{ch, 2'b00} +: 4] <= {y3, y2, y1, y0};
            end

            // A load wins over an accept in the same cycle, so valid stays high.
            if (load_frame) begin
                frame_out   <= shadow;
                frame_valid <= 1'b1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl at SETTLE = 0, 1 and 3

module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        cont;
    logic        ready;
    logic [15:0] pat;

    logic [2:0]  s0_v;
    logic [2:0]  s1_v;
    logic [2:0]  fv_v;
    logic [2:0]  busy_v;
    logic [15:0] fo_v [3];
    logic [3:0]  y_v [3];
    logic [1:0]  prev_sel [3];
    logic [3:0]  junk;

    int n_checks = 0;
    int n_errors = 0;

    // Mux stand-in: shows junk for the first cycle after a select change, then
    // the channel nibble of pat.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if ({s0_v[i], s1_v[i]} == prev_sel[i])
                y_v[i] = pat[{s0_v[i], s1_v[i], 2'b00} +: 4];
            else
                y_v[i] = junk;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) prev_sel[i] <= {s0_v[i], s1_v[i]};
        junk <= 4'($urandom);
    end

    mux_scan_ctrl #(.SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .s0(s0_v[0]), .s1(s1_v[0]),
        .y0(y_v[0][0]), .y1(y_v[0][1]), .y2(y_v[0][2]), .y3(y_v[0][3]),
        .frame_out(fo_v[0]), .frame_valid(fv_v[0]), .frame_ready(ready), .busy(busy_v[0])
    );

    mux_scan_ctrl #(.SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .s0(s0_v[1]), .s1(s1_v[1]),
        .y0(y_v[1][0]), .y1(y_v[1][1]), .y2(y_v[1][2]), .y3(y_v[1][3]),
        .frame_out(fo_v[1]), .frame_valid(fv_v[1]), .frame_ready(ready), .busy(busy_v[1])
    );

    mux_scan_ctrl #(.SETTLE(3)) u3 (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .s0(s0_v[2]), .s1(s1_v[2]),
        .y0(y_v[2][0]), .y1(y_v[2][1]), .y2(y_v[2][2]), .y3(y_v[2][3]),
        .frame_out(fo_v[2]), .frame_valid(fv_v[2]), .frame_ready(ready), .busy(busy_v[2])
    );

    // Reference model: a scan is a position counter over 4*(S+2) cycles,
    // sampling channel pos/(S+2) on the last cycle of each slot, followed by a
    // hand-off step that waits for the output register.
    bit          m_active [3];
    int          m_pos    [3];
    logic [1:0]  m_sel    [3];
    logic [15:0] m_shadow [3];
    logic [15:0] m_fo     [3];
    bit          m_fv     [3];

    function automatic int settle_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int slot;
            int k;
            bit old_fv;
            bit loaded;
            slot   = settle_of(i) + 2;
            old_fv = m_fv[i];
            loaded = 1'b0;
            if (rst) begin
                m_active[i] = 1'b0;
                m_pos[i]    = 0;
                m_sel[i]    = 2'b00;
                m_shadow[i] = 16'h0000;
                m_fo[i]     = 16'h0000;
                m_fv[i]     = 1'b0;
            end else begin
                if (!m_active[i]) begin
                    if (start) begin
                        m_active[i] = 1'b1;
                        m_pos[i]    = 0;
                        m_sel[i]    = 2'b00;
                    end
                end else if (m_pos[i] < 4 * slot) begin
                    if (m_pos[i] % slot == slot - 1) begin
                        k = m_pos[i] / slot;
                        m_shadow[i][4*k +: 4] = pat[4*k +: 4];
                        if (k < 3) m_sel[i] = 2'(k + 1);
                    end
                    m_pos[i]++;
                end else if (!old_fv || ready) begin
                    m_fo[i] = m_shadow[i];
                    loaded  = 1'b1;
                    if (cont) begin
                        m_pos[i] = 0;
                        m_sel[i] = 2'b00;
                    end else begin
                        m_active[i] = 1'b0;
                    end
                end
                if (loaded) m_fv[i] = 1'b1;
                else if (ready) m_fv[i] = 1'b0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model u%0d busy", i), 32'(busy_v[i]), 32'(m_active[i]));
            check($sformatf("model u%0d valid", i), 32'(fv_v[i]), 32'(m_fv[i]));
            check($sformatf("model u%0d sel", i), 32'({s0_v[i], s1_v[i]}), 32'(m_sel[i]));
            check($sformatf("model u%0d frame", i), 32'(fo_v[i]), 32'(m_fo[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    typedef struct {
        bit          rst;
        bit          start;
        bit          cont;
        bit          ready;
        int          n;
        bit          busy;
        bit          valid;
        logic [1:0]  sel;
        logic [15:0] frame;
        bit          chk_frame;
    } vec_t;

    vec_t vecs [10];
    int   valid_at [$];
    int   cnt_frames [3];
    logic [15:0] first_frame;
    logic [1:0]  hist [20];

    initial begin
        // Single scan on u1 (SETTLE=1), pattern FA21; counts are edges per row.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 2'b00, 16'h0000, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 2'b01, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 2'b01, 16'h0000, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 2'b10, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 2'b11, 16'h0000, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 2'b11, 16'hFA21, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 2'b11, 16'hFA21, 1'b1};

        rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b1; pat = 16'hFA21;

        for (int r = 0; r < 10; r++) begin
            rst = vecs[r].rst; start = vecs[r].start;
            cont = vecs[r].cont; ready = vecs[r].ready;
            repeat (vecs[r].n) cycle();
            check($sformatf("vec%0d busy", r), 32'(busy_v[1]), 32'(vecs[r].busy));
            check($sformatf("vec%0d valid", r), 32'(fv_v[1]), 32'(vecs[r].valid));
            check($sformatf("vec%0d sel", r), 32'({s0_v[1], s1_v[1]}), 32'(vecs[r].sel));
            if (vecs[r].chk_frame)
                check($sformatf("vec%0d frame", r), 32'(fo_v[1]), 32'(vecs[r].frame));
        end
        start = 1'b0;

        // Reset for two cycles while u3 is still mid-scan.
        repeat (3) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst u%0d busy", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst u%0d valid", i), 32'(fv_v[i]), 32'd0);
            check($sformatf("rst u%0d sel", i), 32'({s0_v[i], s1_v[i]}), 32'd0);
        end

        // Continuous mode at SETTLE=0: a frame every 9 cycles.
        pat = 16'h5A3C; cont = 1'b1; ready = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            cycle();
            if (fv_v[0]) valid_at.push_back(k);
        end
        check("cont frame count", 32'(valid_at.size()), 32'd6);
        foreach (valid_at[j])
            check($sformatf("cont frame %0d time", j), 32'(valid_at[j]), 32'(9 * (j + 1)));
        cont = 1'b0;
        repeat (30) cycle();
        check("cont stop busy", 32'(busy_v), 32'd0);

        // Backpressure: two frames with ready low, then a single ready cycle.
        pat = 16'h1234; ready = 1'b0; cont = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            cycle();
            if (k == 13) begin
                first_frame = fo_v[1];
                check("bp first frame", 32'(fo_v[1]), 32'h1234);
                pat = 16'hBEEF;
            end else if (k > 13) begin
                check("bp hold frame", 32'(fo_v[1]), 32'h1234);
                check("bp hold valid", 32'(fv_v[1]), 32'd1);
                check("bp stall busy", 32'(busy_v[1]), 32'd1);
            end
        end
        cont = 1'b0; ready = 1'b1;
        cycle();
        ready = 1'b0;
        check("bp reload valid", 32'(fv_v[1]), 32'd1);
        check("bp reload frame", 32'(fo_v[1]), 32'hBEEF);
        check("bp reload busy", 32'(busy_v[1]), 32'd0);
        repeat (3) cycle();
        ready = 1'b1;
        repeat (2) cycle();
        check("bp drained", 32'(fv_v), 32'd0);

        // start pulsed while busy must not produce an extra frame.
        for (int pass = 0; pass < 2; pass++) begin
            pat = 16'($urandom);
            cont = (pass == 1); ready = 1'b1; start = 1'b1;
            cnt_frames = '{0, 0, 0};
            cycle();
            start = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                if (k == 5) begin
                    if (pass == 0) start = 1'b1;
                    else cont = 1'b0;
                end else begin
                    start = 1'b0;
                end
                cycle();
                for (int i = 0; i < 3; i++) if (fv_v[i]) cnt_frames[i]++;
            end
            for (int i = 0; i < 3; i++)
                check($sformatf("one frame pass%0d u%0d", pass, i), 32'(cnt_frames[i]), 32'd1);
            check($sformatf("idle after pass%0d", pass), 32'(busy_v), 32'd0);
        end

        // Settle at SETTLE=3: each select held 5 cycles.
        pat = 16'($urandom); cont = 1'b0; ready = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        hist[0] = {s0_v[2], s1_v[2]};
        for (int k = 1; k < 20; k++) begin
            cycle();
            hist[k] = {s0_v[2], s1_v[2]};
        end
        for (int k = 0; k < 20; k++)
            check($sformatf("settle3 sel k=%0d", k), 32'(hist[k]), 32'((k / 5 > 3) ? 3 : k / 5));
        repeat (10) cycle();

        // Randomized stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) cont = ~cont;
            ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0) pat = 16'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
